race_arbiter: RTL and testbench

RACE_ARBITER -- requirements
Module: race_arbiter

---
 rtl/race_arbiter_pkg.sv | 38 +++
 rtl/race_arbiter_bcd2_counter.sv | 27 ++
 rtl/race_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_race_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/race_arbiter_pkg.sv
// Shared types for the two-player race arbiter: FSM states, player and key encodings, BCD digits.
package race_pkg;

    localparam int unsigned NUM_PLAYERS = 2;
    localparam int unsigned SCORE_BIN_W = 7;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_GRANT     = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_OVER      = 3'd4
    } state_t;

    typedef enum logic {
        PLAYER_1 = 1'b0,
        PLAYER_2 = 1'b1
    } player_t;

    typedef enum logic [1:0] {
        KEY_NONE  = 2'b00,
        KEY_RIGHT = 2'b01,
        KEY_LEFT  = 2'b10,
        KEY_BOTH  = 2'b11
    } key_t;

    typedef logic [3:0] bcd_digit_t;

    // Box a key points at: left key -> box 0, right key -> box 1.
    function automatic logic key_to_box(key_t k);
        return k == KEY_RIGHT;
    endfunction

    function automatic logic [SCORE_BIN_W-1:0] bcd_to_bin(bcd_digit_t tens, bcd_digit_t ones);
        return SCORE_BIN_W'(tens) * SCORE_BIN_W'(10) + SCORE_BIN_W'(ones);
    endfunction

endpackage

// File: rtl/race_arbiter_bcd2_counter.sv
// Two-digit BCD score counter with synchronous clear and single-step increment (99 wraps to 00).
module bcd2_counter
    import race_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output bcd_digit_t digit0,
    output bcd_digit_t digit1
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            digit0 <= '0;
            digit1 <= '0;
        end else if (inc) begin
            if (digit0 == 4'd9) begin
                digit0 <= '0;
                digit1 <= (digit1 == 4'd9) ? 4'd0 : digit1 + 4'd1;
            end else begin
                digit0 <= digit0 + 4'd1;
            end
        end
    end

endmodule

// File: rtl/race_arbiter.sv
// Two-player button race arbiter: captures presses, serialises grants to a shared plotter, keeps BCD scores.
// Define RACE_ARB_LOCKOUT_EN to lock a player out for LOCK_CYCLES after a wrong press.
module race_arbiter
    import race_pkg::*;
#(
    parameter int unsigned TARGET      = 20,
    parameter int unsigned LOCK_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] p1_key,
    input  logic [1:0] p2_key,
    input  logic       p1_box,
    input  logic       p2_box,
    input  logic       plot_done,
    output logic       plot_req,
    output logic       plot_player,
    output logic [1:0] advance,
    output logic [3:0] p1_score0,
    output logic [3:0] p1_score1,
    output logic [3:0] p2_score0,
    output logic [3:0] p2_score1,
    output logic       game_over,
    output logic [1:0] winner
);

    if (TARGET < 1 || TARGET > 99 || LOCK_CYCLES < 1) begin : g_bad_cfg
        $error("race_arbiter: TARGET must be 1..99 and LOCK_CYCLES at least 1");
    end

    state_t                  state;
    player_t                 gnt;
    player_t                 last_grant;
    player_t                 pick_c;
    key_t                    key_in   [NUM_PLAYERS];
    key_t                    key_prev [NUM_PLAYERS];
    key_t                    pend_key [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0]  pend;
    logic [NUM_PLAYERS-1:0]  press_c;
    logic [NUM_PLAYERS-1:0]  locked;
    logic [NUM_PLAYERS-1:0]  box_in;
    logic [NUM_PLAYERS-1:0]  score_inc_c;
    logic                    score_clr_c;
    logic                    match_c;
    logic [SCORE_BIN_W-1:0]  gnt_score_c;

    assign key_in[0] = key_t'(p1_key);
    assign key_in[1] = key_t'(p2_key);
    assign box_in    = {p2_box, p1_box};

    always_ff @(posedge clk) begin
        key_prev[0] <= key_in[0];
        key_prev[1] <= key_in[1];
    end

    // A press is a clean 00 -> single-key edge while the game is live.
    always_comb begin
        press_c = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            press_c[p] = (state == ST_PLAY || state == ST_GRANT || state == ST_WAIT_DONE)
                      && key_prev[p] == KEY_NONE
                      && (key_in[p] == KEY_LEFT || key_in[p] == KEY_RIGHT)
                      && !locked[p];
        end
    end

    // Ties go to whoever was not served last.
    always_comb begin
        pick_c = PLAYER_1;
        if (pend == 2'b11) begin
            pick_c = (last_grant == PLAYER_1) ? PLAYER_2 : PLAYER_1;
        end else if (pend[1]) begin
            pick_c = PLAYER_2;
        end
    end

    assign match_c     = key_to_box(pend_key[gnt]) == box_in[gnt];
    assign score_inc_c = (state == ST_GRANT && match_c)
                       ? ((gnt == PLAYER_2) ? 2'b10 : 2'b01) : 2'b00;
    assign score_clr_c = (state == ST_IDLE) && start;
    assign gnt_score_c = (gnt == PLAYER_2) ? bcd_to_bin(p2_score1, p2_score0)
                                           : bcd_to_bin(p1_score1, p1_score0);

`ifdef RACE_ARB_LOCKOUT_EN
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);

    logic [LOCK_W-1:0]      lock_cnt [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] lock_load_c;

    assign lock_load_c = {gnt == PLAYER_2, gnt == PLAYER_1}
                       & {NUM_PLAYERS{state == ST_GRANT && !match_c}};

    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt[0] <= '0;
            lock_cnt[1] <= '0;
        end else begin
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (lock_load_c[p]) begin
                    lock_cnt[p] <= LOCK_W'(LOCK_CYCLES);
                end else if (lock_cnt[p] != '0) begin
                    lock_cnt[p] <= lock_cnt[p] - LOCK_W'(1);
                end
            end
        end
    end

    always_comb begin
        locked = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            locked[p] = lock_cnt[p] != '0;
        end
    end
`else
    assign locked = '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pend        <= '0;
            pend_key[0] <= KEY_NONE;
            pend_key[1] <= KEY_NONE;
            gnt         <= PLAYER_1;
            last_grant  <= PLAYER_2;
            plot_req    <= 1'b0;
            plot_player <= 1'b0;
            advance     <= '0;
            game_over   <= 1'b0;
            winner      <= '0;
        end else begin
            advance <= '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                if (press_c[p] && !pend[p]) begin
                    pend[p]     <= 1'b1;
                    pend_key[p] <= key_in[p];
                end
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_PLAY;
                        pend   <= '0;
                        winner <= '0;
                    end
                end
                ST_PLAY: begin
                    if (!start) begin
                        state <= ST_IDLE;
                    end else if (pend != '0) begin
                        state      <= ST_GRANT;
                        gnt        <= pick_c;
                        last_grant <= pick_c;
                    end
                end
                ST_GRANT: begin
                    pend[gnt] <= 1'b0;
                    if (match_c) begin
                        state       <= ST_WAIT_DONE;
                        advance     <= score_inc_c;
                        plot_req    <= 1'b1;
                        plot_player <= gnt;
                    end else begin
                        state <= ST_PLAY;
                    end
                end
                ST_WAIT_DONE: begin
                    if (plot_done) begin
                        plot_req <= 1'b0;
                        if (gnt_score_c == SCORE_BIN_W'(TARGET)) begin
                            state     <= ST_OVER;
                            game_over <= 1'b1;
                            winner    <= (gnt == PLAYER_2) ? 2'b10 : 2'b01;
                        end else begin
                            state <= ST_PLAY;
                        end
                    end
                end
                ST_OVER: begin
                    if (!start) begin
                        state     <= ST_IDLE;
                        game_over <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    bcd2_counter u_p1_score (
        .clk    (clk),
        .reset  (reset),
        .clear  (score_clr_c),
        .inc    (score_inc_c[0]),
        .digit0 (p1_score0),
        .digit1 (p1_score1)
    );

    bcd2_counter u_p2_score (
        .clk    (clk),
        .reset  (reset),
        .clear  (score_clr_c),
        .inc    (score_inc_c[1]),
        .digit0 (p2_score0),
        .digit1 (p2_score1)
    );

endmodule

// File: tb/tb_race_arbiter.sv
// Bench for race_arbiter: directed scenarios plus random play against an integer-score reference model.
module tb_race_arbiter;

    localparam int unsigned TGT   = 12;
    localparam int unsigned LOCKN = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] p1_key;
    logic [1:0] p2_key;
    logic       p1_box;
    logic       p2_box;
    logic       plot_done;
    logic       plot_req;
    logic       plot_player;
    logic [1:0] advance;
    logic [3:0] p1_score0;
    logic [3:0] p1_score1;
    logic [3:0] p2_score0;
    logic [3:0] p2_score1;
    logic       game_over;
    logic [1:0] winner;

    race_arbiter #(.TARGET(TGT), .LOCK_CYCLES(LOCKN)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .p1_key      (p1_key),
        .p2_key      (p2_key),
        .p1_box      (p1_box),
        .p2_box      (p2_box),
        .plot_done   (plot_done),
        .plot_req    (plot_req),
        .plot_player (plot_player),
        .advance     (advance),
        .p1_score0   (p1_score0),
        .p1_score1   (p1_score1),
        .p2_score0   (p2_score0),
        .p2_score1   (p2_score1),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 play, 2 grant, 3 wait for plotter, 4 game over.
    int         m_mode = 0;
    bit         m_pend [2];
    logic [1:0] m_pkey [2];
    logic [1:0] m_prev [2];
    int         m_last = 1;
    int         m_gnt  = 0;
    int         m_score [2];
    int         m_lock [2];
    bit         m_plot_req = 0;
    int         m_plot_player = 0;
    logic [1:0] m_adv = 2'b00;
    bit         m_over = 0;
    logic [1:0] m_win = 2'b00;

    int plot_lat  = 3;
    int plot_wait = 0;

    function automatic logic [7:0] bcd(input int s);
        return 8'(((s / 10) % 10) * 16 + (s % 10));
    endfunction

    task automatic model_step();
        logic [1:0] k [2];
        logic       b [2];
        bit         fresh [2];
        int         nxt;
        k[0] = p1_key;
        k[1] = p2_key;
        b[0] = p1_box;
        b[1] = p2_box;
        if (reset) begin
            m_mode = 0;  m_pend = '{0, 0};  m_last = 1;  m_gnt = 0;
            m_score = '{0, 0};  m_lock = '{0, 0};
            m_plot_req = 0;  m_plot_player = 0;  m_adv = 2'b00;  m_over = 0;  m_win = 2'b00;
            m_prev = k;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            fresh[p] = (m_mode >= 1 && m_mode <= 3) && m_prev[p] == 2'b00
                    && (k[p] == 2'b01 || k[p] == 2'b10) && m_lock[p] == 0 && !m_pend[p];
            if (m_lock[p] > 0) m_lock[p]--;
        end
        m_adv = 2'b00;
        nxt = m_mode;
        case (m_mode)
            0: if (start) begin
                nxt = 1;  m_score = '{0, 0};  m_pend = '{0, 0};  m_win = 2'b00;
            end
            1: if (!start) nxt = 0;
               else if (m_pend[0] || m_pend[1]) begin
                   if (m_pend[0] && m_pend[1]) m_gnt = 1 - m_last;
                   else m_gnt = m_pend[1] ? 1 : 0;
                   m_last = m_gnt;
                   nxt = 2;
               end
            2: begin
                m_pend[m_gnt] = 0;
                if (b[m_gnt] == (m_pkey[m_gnt] == 2'b01)) begin
                    m_score[m_gnt]++;
                    m_adv[m_gnt] = 1'b1;
                    m_plot_req = 1;
                    m_plot_player = m_gnt;
                    nxt = 3;
                end else begin
`ifdef RACE_ARB_LOCKOUT_EN
                    m_lock[m_gnt] = LOCKN;
`endif
                    nxt = 1;
                end
            end
            3: if (plot_done) begin
                m_plot_req = 0;
                if (m_score[m_gnt] == TGT) begin
                    nxt = 4;  m_over = 1;  m_win = (m_gnt == 1) ? 2'b10 : 2'b01;
                end else nxt = 1;
            end
            4: if (!start) begin nxt = 0; m_over = 0; end
            default: nxt = 0;
        endcase
        for (int p = 0; p < 2; p++) begin
            if (fresh[p]) begin m_pend[p] = 1; m_pkey[p] = k[p]; end
        end
        m_prev = k;
        m_mode = nxt;
    endtask

    task automatic compare_all();
        check("plot_req", 8'(plot_req), 8'(m_plot_req));
        check("plot_player", 8'(plot_player), 8'(m_plot_player));
        check("advance", 8'(advance), 8'(m_adv));
        check("p1_score", {p1_score1, p1_score0}, bcd(m_score[0]));
        check("p2_score", {p2_score1, p2_score0}, bcd(m_score[1]));
        check("over_winner", 8'({game_over, winner}), 8'({m_over, m_win}));
    endtask

    // One clock: model and DUT advance together, outputs compared mid-cycle, plotter answers.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
        if (m_plot_req) begin
            plot_done = (plot_wait == plot_lat);
            plot_wait++;
        end else begin
            plot_done = 1'b0;
            plot_wait = 0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;  start = 1'b0;  p1_key = 2'b00;  p2_key = 2'b00;
        ticks(2);
        reset = 1'b0;
    endtask

    task automatic press(input int p, input logic [1:0] k, input int wait_n);
        if (p == 0) p1_key = k; else p2_key = k;
        tick();
        if (p == 0) p1_key = 2'b00; else p2_key = 2'b00;
        ticks(wait_n);
    endtask

    logic [1:0] first_adv;
    int         adv_cnt;
    logic       pp_seen;
    bit         seen;
    int         r;

    initial begin
        reset = 1'b1;  start = 1'b0;  p1_key = 2'b00;  p2_key = 2'b00;
        p1_box = 1'b0;  p2_box = 1'b0;  plot_done = 1'b0;

        // Reset state
        do_reset();
        check("rst_plot_req", 8'(plot_req), 8'd0);
        check("rst_scores", {p1_score1, p1_score0, p2_score1, p2_score0} == 16'h0 ? 8'd0 : 8'd1, 8'd0);
        check("rst_over", 8'({game_over, winner}), 8'd0);

        // Single correct P1 press, plotter answers 3 cycles in
        start = 1'b1;  tick();
        plot_lat = 3;  p1_box = 1'b0;
        adv_cnt = 0;  pp_seen = 1'b1;
        p1_key = 2'b10;  tick();  p1_key = 2'b00;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (advance[0]) adv_cnt++;
            if (plot_req) pp_seen = plot_player;
        end
        check("t1_adv_pulses", 8'(adv_cnt), 8'd1);
        check("t1_p1_score", {p1_score1, p1_score0}, 8'h01);
        check("t1_plot_player", 8'(pp_seen), 8'd0);

        // Simultaneous correct presses: P1 served first
        do_reset();  start = 1'b1;  tick();
        p1_box = 1'b0;  p2_box = 1'b1;  first_adv = 2'b00;
        p1_key = 2'b10;  p2_key = 2'b01;  tick();
        p1_key = 2'b00;  p2_key = 2'b00;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (first_adv == 2'b00) first_adv = advance;
        end
        check("t2_first_served", 8'(first_adv), 8'h01);
        check("t2_p1_score", {p1_score1, p1_score0}, 8'h01);
        check("t2_p2_score", {p2_score1, p2_score0}, 8'h01);

        // Ones-to-tens carry
        do_reset();  start = 1'b1;  tick();
        p1_box = 1'b1;
        for (int i = 0; i < 9; i++) press(0, 2'b01, 10);
        check("t3_p1_09", {p1_score1, p1_score0}, 8'h09);
        press(0, 2'b01, 10);
        check("t3_p1_10", {p1_score1, p1_score0}, 8'h10);

        // P2 reaches target; later presses ignored
        do_reset();  start = 1'b1;  tick();
        p1_box = 1'b0;  p2_box = 1'b1;
        for (int i = 0; i < int'(TGT); i++) press(1, 2'b01, 10);
        check("t4_game_over", 8'(game_over), 8'd1);
        check("t4_winner", 8'(winner), 8'h02);
        press(1, 2'b01, 10);
        press(0, 2'b10, 10);
        check("t4_p2_held", {p2_score1, p2_score0}, 8'h12);
        check("t4_p1_held", {p1_score1, p1_score0}, 8'h00);
        start = 1'b0;  ticks(2);
        check("t4_back_idle", 8'(game_over), 8'd0);

        // Wrong press, then an immediate retry
        do_reset();  start = 1'b1;  tick();
        p1_box = 1'b1;
        p1_key = 2'b10;  tick();
        p1_key = 2'b00;  ticks(2);
        p1_box = 1'b0;
        p1_key = 2'b10;  tick();
        p1_key = 2'b00;  ticks(10);
`ifdef RACE_ARB_LOCKOUT_EN
        check("t5_retry_score", {p1_score1, p1_score0}, 8'h00);
`else
        check("t5_retry_score", {p1_score1, p1_score0}, 8'h01);
`endif
        press(0, 2'b10, 10);
`ifdef RACE_ARB_LOCKOUT_EN
        check("t5_after_lock", {p1_score1, p1_score0}, 8'h01);
`else
        check("t5_after_lock", {p1_score1, p1_score0}, 8'h02);
`endif

        // Reset while the plotter handshake is open
        do_reset();  start = 1'b1;  tick();
        plot_lat = 30;  p1_box = 1'b0;
        p1_key = 2'b10;  tick();  p1_key = 2'b00;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (plot_req) seen = 1;
        end
        check("t6_reached_wait", 8'(seen), 8'd1);
        reset = 1'b1;  tick();
        check("t6_plot_req", 8'(plot_req), 8'd0);
        check("t6_p1_score", {p1_score1, p1_score0}, 8'h00);
        reset = 1'b0;

        // Random play
        do_reset();  start = 1'b1;
        for (int c = 0; c < 5000; c++) begin
            reset = ($urandom_range(0, 999) < 2);
            if (start) start = ($urandom_range(0, 199) != 0);
            else       start = ($urandom_range(0, 4) == 0);
            r = $urandom_range(0, 9);
            p1_key = (r < 6) ? 2'b00 : (r < 8) ? 2'b10 : (r == 8) ? 2'b01 : 2'b11;
            r = $urandom_range(0, 9);
            p2_key = (r < 6) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
            p1_box = 1'($urandom_range(0, 1));
            p2_box = 1'($urandom_range(0, 1));
            if (!m_plot_req) plot_lat = $urandom_range(0, 5);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
